// File: rtl/uart_pkg.sv
// Shared UART FIFO definitions: trigger-level encoding, thresholds and default depth.
// Used by uart_rx_fifo (optional error tracking via UART_RX_FIFO_ERR_EN) and the TX side.
package uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } trig_lvl_e;

    localparam int TRIG_THR_1  = 1;
    localparam int TRIG_THR_4  = 4;
    localparam int TRIG_THR_8  = 8;
    localparam int TRIG_THR_14 = 14;

    function automatic int trig_threshold(input logic [1:0] lvl);
        case (trig_lvl_e'(lvl))
            TRIG_1:  return TRIG_THR_1;
            TRIG_4:  return TRIG_THR_4;
            TRIG_8:  return TRIG_THR_8;
            default: return TRIG_THR_14;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Generic FIFO storage: one synchronous write port, one asynchronous read port.
// Shared between the RX and TX FIFOs.
module uart_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with trigger level, sticky overrun and optional per-entry error flags.
// Define UART_RX_FIFO_ERR_EN to store parity/framing/break flags with each character.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pe_in,
    input  logic                     fe_in,
    input  logic                     bi_in,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [1:0]               trig_lvl,
    input  logic                     ovr_clr,
    output logic [7:0]               dout,
    output logic                     pe_out,
    output logic                     fe_out,
    output logic                     bi_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     trig,
    output logic                     overrun,
    output logic                     err_in_fifo
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_RX_FIFO_ERR_EN
    localparam int EW = 11;
`else
    localparam int EW = 8;
`endif

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          trig_q, trig_d;
    logic [EW-1:0] wr_entry, rd_entry;
    logic          empty_w, full_w;
    logic          do_push, do_pop, ovf_evt;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    // Flush blocks both strobes; a pop on an empty FIFO never falls through to a same-cycle push.
    assign do_pop  = pop & ~empty_w & ~flush;
    assign do_push = push & ~flush & (~full_w | do_pop);
    assign ovf_evt = push & full_w & ~pop & ~flush;

`ifdef UART_RX_FIFO_ERR_EN
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          wr_err, rd_err;

    assign wr_entry = {bi_in, fe_in, pe_in, din};
    assign wr_err   = bi_in | fe_in | pe_in;
    assign rd_err   = |rd_entry[10:8];

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (flush) begin
            err_cnt_d = '0;
        end else if ((do_push && wr_err) && !(do_pop && rd_err)) begin
            err_cnt_d = err_cnt_q + CW'(1);
        end else if (!(do_push && wr_err) && (do_pop && rd_err)) begin
            err_cnt_d = err_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pe_out      = rd_entry[8];
    assign fe_out      = rd_entry[9];
    assign bi_out      = rd_entry[10];
    assign err_in_fifo = (err_cnt_q != '0);
`else
    logic unused_flags;

    assign unused_flags = pe_in ^ fe_in ^ bi_in;
    assign wr_entry     = din;
    assign pe_out       = 1'b0;
    assign fe_out       = 1'b0;
    assign bi_out       = 1'b0;
    assign err_in_fifo  = 1'b0;
`endif

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
        overrun_d = (overrun_q & ~ovr_clr) | ovf_evt;
        // Registered so trig tracks count at the same edge and a trig_lvl change lands one cycle later.
        trig_d    = int'(count_d) >= trig_threshold(trig_lvl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            trig_q    <= trig_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign dout    = rd_entry[7:0];
    assign empty   = empty_w;
    assign full    = full_w;
    assign count   = count_q;
    assign trig    = trig_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16); error-flag expectations follow UART_RX_FIFO_ERR_EN.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst, push, pop, flush, ovr_clr;
    logic [7:0] din;
    logic       pe_in, fe_in, bi_in;
    logic [1:0] trig_lvl;
    logic [7:0] dout;
    logic       pe_out, fe_out, bi_out, empty, full, trig, overrun, err_in_fifo;
    logic [4:0] count;

    int nvec = 0;
    int nerr = 0;

`ifdef UART_RX_FIFO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din),
        .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in),
        .pop(pop), .flush(flush), .trig_lvl(trig_lvl), .ovr_clr(ovr_clr),
        .dout(dout), .pe_out(pe_out), .fe_out(fe_out), .bi_out(bi_out),
        .empty(empty), .full(full), .count(count), .trig(trig),
        .overrun(overrun), .err_in_fifo(err_in_fifo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
        push = 1'b1; din = d; pe_in = pe; fe_in = fe; bi_in = bi;
        tick();
        push = 1'b0; pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b1; pop = 1'b1; flush = 1'b1; din = 8'hFF;
        tick(); tick();
        rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL reset_empty got=%b exp=1", empty); end
        nvec++; if (full !== 1'b0) begin nerr++; $display("FAIL reset_full got=%b exp=0", full); end
        nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", count); end
        nvec++; if (trig !== 1'b0) begin nerr++; $display("FAIL reset_trig got=%b exp=0", trig); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        nvec++; if (err_in_fifo !== 1'b0) begin nerr++; $display("FAIL reset_err got=%b exp=0", err_in_fifo); end
    endtask

    task automatic test_single();
        push_byte(8'h45, 1'b0, 1'b0, 1'b0);
        nvec++; if (empty !== 1'b0) begin nerr++; $display("FAIL single_empty got=%b exp=0", empty); end
        nvec++; if (count !== 5'd1) begin nerr++; $display("FAIL single_count got=%0d exp=1", count); end
        nvec++; if (dout !== 8'h45) begin nerr++; $display("FAIL single_dout got=%h exp=45", dout); end
        nvec++; if (trig !== 1'b1) begin nerr++; $display("FAIL single_trig got=%b exp=1", trig); end
        pop_one();
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b0);
        nvec++; if (full !== 1'b1) begin nerr++; $display("FAIL fill_full got=%b exp=1", full); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL fill_ovr_early got=%b exp=0", overrun); end
        push_byte(8'hAA, 1'b0, 1'b0, 1'b0);
        nvec++; if (full !== 1'b1) begin nerr++; $display("FAIL ovr_full got=%b exp=1", full); end
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        nvec++; if (count !== 5'd16) begin nerr++; $display("FAIL ovr_count got=%0d exp=16", count); end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (dout !== 8'(i)) begin nerr++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, dout, 8'(i)); end
            pop_one();
        end
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL drain_empty got=%b exp=1", empty); end
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
    endtask

    task automatic test_pop_empty();
        // Read pointer sits on address 1, which last held 0x00.
        pop_one();
        nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL popempty_count got=%0d exp=0", count); end
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL popempty_empty got=%b exp=1", empty); end
        nvec++; if (dout !== 8'h00) begin nerr++; $display("FAIL popempty_dout got=%h exp=00", dout); end
    endtask

    task automatic test_trigger();
        trig_lvl = 2'b10;
        for (int i = 0; i < 7; i++) push_byte(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        nvec++; if (trig !== 1'b0) begin nerr++; $display("FAIL trig7 got=%b exp=0", trig); end
        push_byte(8'h27, 1'b0, 1'b0, 1'b0);
        nvec++; if (trig !== 1'b1) begin nerr++; $display("FAIL trig8 got=%b exp=1", trig); end
        pop_one();
        nvec++; if (trig !== 1'b0) begin nerr++; $display("FAIL trig_pop got=%b exp=0", trig); end
        trig_lvl = 2'b01;
        #1;
        nvec++; if (trig !== 1'b0) begin nerr++; $display("FAIL trig_lvl_same_cycle got=%b exp=0", trig); end
        tick();
        nvec++; if (trig !== 1'b1) begin nerr++; $display("FAIL trig_lvl_next got=%b exp=1", trig); end
        for (int i = 0; i < 7; i++) pop_one();
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL trig_drain got=%b exp=1", empty); end
    endtask

    task automatic test_err();
        push_byte(8'h12, 1'b0, 1'b1, 1'b0);
        push_byte(8'h34, 1'b0, 1'b0, 1'b0);
        nvec++; if (err_in_fifo !== ERR_EN) begin nerr++; $display("FAIL err_set got=%b exp=%b", err_in_fifo, ERR_EN); end
        nvec++; if (fe_out !== ERR_EN) begin nerr++; $display("FAIL err_fe_head got=%b exp=%b", fe_out, ERR_EN); end
        nvec++; if (dout !== 8'h12) begin nerr++; $display("FAIL err_dout got=%h exp=12", dout); end
        pop_one();
        nvec++; if (err_in_fifo !== 1'b0) begin nerr++; $display("FAIL err_clear got=%b exp=0", err_in_fifo); end
        nvec++; if (fe_out !== 1'b0) begin nerr++; $display("FAIL err_fe_next got=%b exp=0", fe_out); end
        // Erroneous push and clean pop together: counter goes 0 -> 1.
        push = 1'b1; pop = 1'b1; din = 8'h56; bi_in = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0; bi_in = 1'b0;
        nvec++; if (err_in_fifo !== ERR_EN) begin nerr++; $display("FAIL err_pushpop got=%b exp=%b", err_in_fifo, ERR_EN); end
        nvec++; if (bi_out !== ERR_EN) begin nerr++; $display("FAIL err_bi_head got=%b exp=%b", bi_out, ERR_EN); end
        pop_one();
        nvec++; if (err_in_fifo !== 1'b0) begin nerr++; $display("FAIL err_final got=%b exp=0", err_in_fifo); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        push = 1'b1; pop = 1'b1; din = 8'h99;
        tick();
        push = 1'b0; pop = 1'b0;
        nvec++; if (count !== 5'd16) begin nerr++; $display("FAIL b2b_full_count got=%0d exp=16", count); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL b2b_full_ovr got=%b exp=0", overrun); end
        nvec++; if (dout !== 8'h81) begin nerr++; $display("FAIL b2b_full_head got=%h exp=81", dout); end
        for (int i = 0; i < 15; i++) pop_one();
        nvec++; if (dout !== 8'h99) begin nerr++; $display("FAIL b2b_tail got=%h exp=99", dout); end
        pop_one();
        push = 1'b1; pop = 1'b1; din = 8'h77;
        tick();
        push = 1'b0; pop = 1'b0;
        nvec++; if (count !== 5'd1) begin nerr++; $display("FAIL b2b_empty_count got=%0d exp=1", count); end
        nvec++; if (dout !== 8'h77) begin nerr++; $display("FAIL b2b_empty_dout got=%h exp=77", dout); end
        pop_one();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        push_byte(8'hEE, 1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b1;
        push_byte(8'hEF, 1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_clr_vs_set got=%b exp=1", overrun); end
        for (int i = 0; i < 11; i++) pop_one();
        nvec++; if (count !== 5'd5) begin nerr++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
        flush = 1'b1; push = 1'b1; din = 8'h11;
        tick();
        flush = 1'b0; push = 1'b0;
        nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL flush_count got=%0d exp=0", count); end
        nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL flush_empty got=%b exp=1", empty); end
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL flush_ovr got=%b exp=1", overrun); end
        push_byte(8'h5A, 1'b0, 1'b0, 1'b0);
        nvec++; if (dout !== 8'h5A) begin nerr++; $display("FAIL flush_after_dout got=%h exp=5a", dout); end
        nvec++; if (count !== 5'd1) begin nerr++; $display("FAIL flush_after_count got=%0d exp=1", count); end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
        din = 8'h00; pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0; trig_lvl = 2'b00;
        test_reset();
        test_single();
        test_fill_overrun();
        test_pop_empty();
        test_trigger();
        test_err();
        test_back_to_back();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of entries; SHALL be a power of two and at least 4.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port push  input  1  one-cycle write strobe from the UART receiver.
REQ-005 Port din  input  8  received character.
REQ-006 Port pe_in / fe_in / bi_in  input  1 each  parity, framing and break flags for din.
REQ-007 Port pop  input  1  one-cycle read strobe from the register interface.
REQ-008 Port flush  input  1  synchronous FIFO clear (FCR bit 1).
REQ-009 Port trig_lvl  input  2  receive trigger select: 00=1, 01=4, 10=8, 11=14 entries.
REQ-010 Port ovr_clr  input  1  clears the overrun flag (LSR read).
REQ-011 Port dout  output  8  head-entry character.
REQ-012 Port pe_out / fe_out / bi_out  output  1 each  head-entry flags.
REQ-013 Port empty / full  output  1 each  occupancy status.
REQ-014 Port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-015 Port trig  output  1  asserted when count is at or above the selected trigger level.
REQ-016 Port overrun  output  1  sticky overrun flag.
REQ-017 Port err_in_fifo  output  1  asserted when any stored entry has pe, fe or bi set.

Function
REQ-018 Storage SHALL be a circular buffer with wrapping rd_ptr and wr_ptr plus an occupancy counter; pointer wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-019 push with full=0 SHALL write {bi_in, fe_in, pe_in, din} at wr_ptr and increment count; status SHALL update at the same edge (1-cycle latency).
REQ-020 dout and the flag outputs SHALL be combinational from the entry at rd_ptr; pop with empty=0 SHALL advance rd_ptr and decrement count.
REQ-021 pop with empty=1 SHALL be ignored; outputs SHALL hold their values.
REQ-022 push with full=1 and pop=0 SHALL discard the write and set overrun; stored data SHALL be unchanged.
REQ-023 push and pop in the same cycle with full=1 SHALL accept both; count is unchanged and overrun is not set.
REQ-024 push and pop in the same cycle with empty=1 SHALL accept the push only (no fall-through); count becomes 1.
REQ-025 push and pop in the same cycle in any other state SHALL accept both with count unchanged.
REQ-026 overrun SHALL stay set until ovr_clr; if ovr_clr and a new overrun occur in the same cycle, overrun SHALL remain 1.
REQ-027 err_in_fifo SHALL be driven by an error-entry counter, incremented on accepted erroneous pushes and decremented on pops of erroneous entries; simultaneous events SHALL net out.
REQ-028 trig SHALL be recomputed every cycle from count and trig_lvl; a trig_lvl change SHALL take effect in the next cycle.
REQ-029 flush SHALL take priority over push and pop in the same cycle: pointers, count and error counter go to 0; overrun SHALL be unaffected.

Reset
REQ-030 On rst, pointers, count, error counter and overrun SHALL be 0; empty=1, full=0, trig=0, err_in_fifo=0.
REQ-031 rst SHALL override flush, push and pop; storage contents need not be cleared.

Configuration
REQ-032 Macro UART_RX_FIFO_ERR_EN defined: entries are 11 bits wide and REQ-012/REQ-027 apply as written.
REQ-033 Macro UART_RX_FIFO_ERR_EN undefined: entries are 8 bits wide; pe_out, fe_out, bi_out and err_in_fifo SHALL be tied to 0; the flag inputs SHALL be ignored.

Structure
REQ-034 Package uart_pkg SHALL hold the trig_lvl enum, the trigger-threshold lookup constants and a default depth constant shared with the transmit side.
REQ-035 Sub-module uart_fifo_ram (parameterised width and depth, one write port, one asynchronous read port) SHALL implement the storage so that the TX FIFO can reuse it.

Verification
REQ-036 Reset, then push 0x45 with no flags -> next cycle empty=0, count=1, dout=0x45; then pop -> empty=1.
REQ-037 Push 16 bytes 0x00..0x0F, then push 0xAA -> full=1, overrun=1, count=16; 16 pops return 0x00..0x0F in order; ovr_clr -> overrun=0.
REQ-038 trig_lvl=10, push 7 bytes -> trig=0; push an 8th -> trig=1; pop 1 -> trig=0.
REQ-039 Push 0x12 with fe_in=1, then 0x34 clean -> err_in_fifo=1 and fe_out=1 at the head; pop once -> err_in_fifo=0.
REQ-040 With full=1, push and pop in the same cycle -> count=16 and overrun=0; with empty=1, push and pop in the same cycle -> count=1.
REQ-041 Flush with 5 entries stored while push is asserted -> count=0 and empty=1 next cycle; an overrun already set stays set.
